adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Shares one instance of the team's 32-bit combinational Adder (ports op1, op2, res) between N_REQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- Operands are registered before the add, and the result is registered after it.
- A single response channel returns the sum and the ID of the requester that issued it. The block sits between the core's functional units and the shared Adder.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 32, operand/result width; must match the Adder.
- ID_W, 2, width of the requester ID; equals clog2(N_REQ).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_op1  in  N_REQ*W  packed operand 1; requester i uses bits [i*W +: W].
- req_op2  in  N_REQ*W  packed operand 2; same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_res  out  W  sum, op1+op2 mod 2^W.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_res=0, busy=0, operand registers=0.
  - Reset mid-operation discards any latched operands and any undelivered response, without exception.
  - req_ready is combinationally 0 while rst=1.
- States:
  - IDLE: can_accept=1. If any req_valid is set, grant and latch -> EXEC. Otherwise stay in IDLE.
  - EXEC: the Adder sees the latched op1/op2. At the edge, res -> rsp_res and the latched ID -> rsp_id, rsp_valid=1 -> RESP. EXEC always lasts exactly 1 cycle.
  - RESP: rsp_valid=1; can_accept=rsp_ready.
    - rsp_ready=1 with a pending request: response retires, new request is latched -> EXEC (back-to-back, one op per 2 cycles).
    - rsp_ready=1 with no request: rsp_valid=0 -> IDLE.
    - rsp_ready=0: hold rsp_res, rsp_id and rsp_valid stable; no new grant.
- Arbitration (combinational):
  - Search from rr_ptr upward, modulo N_REQ; the first i with req_valid[i]=1 wins.
  - req_ready[i] = win[i] & can_accept.
  - On accept of i: rr_ptr <= (i+1) mod N_REQ, and the operands and ID of i are latched. rr_ptr is unchanged when nothing is accepted.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i]. Requesters hold their valid and operands until accepted.
  - req_ready never depends on the requester's own operand values.
- Latency: accept at edge t -> rsp_valid high after edge t+1 (the response is visible 2 edges after the request is first presented in IDLE).
- Arithmetic: unsigned modulo 2^W, with no carry or overflow flag. Negative operands are two's complement and wrap naturally, e.g. 20 + (-5) = 15.
- Simultaneous events:
  - The response retiring and a new accept in the same RESP cycle is legal and required.
  - All N_REQ requesters valid at once are served in pointer order, with no starvation: each waits at most N_REQ-1 grants.
- A requester that drops req_valid before acceptance is simply skipped; no grant is recorded for it.

Decomposition:
- Package adder_arb_pkg holds:
  - state enum {IDLE, EXEC, RESP};
  - localparams W=32 and N_REQ=4 as defaults;
  - the helper function clog2 used for ID_W.
- Sub-module rr_arbiter:
  - Parameter: N.
  - Inputs: req[N-1:0], ptr.
  - Outputs: one-hot gnt, gnt_id, any.
  - Purely combinational; the pointer register stays in adder_arbiter.
- The existing Adder module is instantiated unmodified. adder_arbiter holds all sequential state.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then no requests -> rsp_valid=0, busy=0, req_ready=0000 throughout.
- Single request: req0 presents op1=15, op2=10 -> req_ready[0]=1 for one cycle; after 2 edges rsp_valid=1, rsp_id=0, rsp_res=25. Also op1=20, op2=-5 (0xFFFFFFFB) -> rsp_res=15.
- Round-robin fairness, with rsp_ready=1:
  - All four requesters valid continuously: req0 33+11, req1 1+10, req2 25+999, req3 0xFFFFFFFF+1.
  - Responses must arrive in ID order 0,1,2,3,0,... with rsp_res 44, 11, 1024, 0 (wrap), one response every 2 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles while req1 and req2 are valid -> rsp_res/rsp_id stable and req_ready=0000. When rsp_ready rises, the next grant occurs in that same cycle.
- Reset mid-operation: assert rst during EXEC for a request of 7+8 -> no response with 15 ever appears; after release rr_ptr=0, so with req3 and req0 both valid, req0 is granted first.

Source files
------------

// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_arb_pkg
// Description : Shared types, default sizes and helpers for adder_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int W     = 32;
    localparam int N_REQ = 4;

    // Never returns 0, so a requester ID always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module      : Adder
// Description : Shared combinational adder, res = op1 + op2 mod 2^W.
// Revision    : 1.0 - initial release
// ============================================================================
module Adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    output logic [W-1:0] res
);

    assign res = op1 + op2;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick, searching upward from ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        w_idx  = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = ID_W'((int'(ptr) + k) % N);
            if (!any && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
                any        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin sharing of one Adder between N_REQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = adder_arb_pkg::N_REQ,
    parameter int W     = adder_arb_pkg::W,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_op1,
    input  logic [N_REQ*W-1:0] req_op2,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_res,
    output logic               busy
);

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [W-1:0]    r_op1;
    logic [W-1:0]    r_op2;
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;
    logic [W-1:0]    r_rsp_res;

    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_gnt_id;
    logic             w_any;
    logic             w_can_accept;
    logic             w_accept;
    logic [W-1:0]     w_sum;
    logic [ID_W-1:0]  w_next_ptr;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (r_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id),
        .any    (w_any)
    );

    Adder #(
        .W (W)
    ) u_adder (
        .op1 (r_op1),
        .op2 (r_op2),
        .res (w_sum)
    );

    // A retiring response frees the adder in the same cycle.
    assign w_can_accept = !rst && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
    assign w_accept     = w_can_accept && w_any;
    assign req_ready    = w_can_accept ? w_gnt : '0;
    assign w_next_ptr   = ID_W'((int'(w_gnt_id) + 1) % N_REQ);

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_res   <= '0;
        end else begin
            if (w_accept) begin
                r_op1 <= req_op1[int'(w_gnt_id)*W +: W];
                r_op2 <= req_op2[int'(w_gnt_id)*W +: W];
                r_id  <= w_gnt_id;
                r_ptr <= w_next_ptr;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= EXEC;
                end
                EXEC: begin
                    r_rsp_res   <= w_sum;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Directed and random checks of adder_arbiter against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int N_REQ = 4;
    localparam int W     = 32;
    localparam int ID_W  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_op1;
    logic [N_REQ*W-1:0] req_op2;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [W-1:0]       rsp_res;
    logic               busy;

    adder_arbiter #(
        .N_REQ (N_REQ),
        .W     (W),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one op in flight in the adder, one response waiting.
    int         m_ptr = 0;
    bit         m_op = 1'b0;
    bit         m_pend = 1'b0;
    int         m_op_id = 0;
    logic [W-1:0] m_sum = '0;
    int         m_id = 0;
    logic [W-1:0] m_res = '0;

    // 0: drop valid once accepted, 1: hold valid forever, 2: random traffic
    int               mode = 0;
    int               cycle = 0;
    logic             obs_valid;
    logic [ID_W-1:0]  obs_id;
    logic [W-1:0]     obs_res;
    logic [N_REQ-1:0] obs_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N_REQ; k++) begin
            if (req_valid[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]       = v;
        req_op1[i*W +: W]  = a;
        req_op2[i*W +: W]  = b;
    endtask

    task automatic step();
        int               w;
        bit               can;
        logic [N_REQ-1:0] exp_rdy;
        @(negedge clk);
        w   = winner();
        can = !rst && !m_op && (!m_pend || rsp_ready);
        exp_rdy = (can && w >= 0) ? (N_REQ'(1) << w) : '0;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, m_pend);
        check("busy", busy, m_op || m_pend);
        if (m_pend) begin
            check("rsp_id", rsp_id, m_id);
            check("rsp_res", rsp_res, m_res);
        end
        obs_valid = rsp_valid;
        obs_id    = rsp_id;
        obs_res   = rsp_res;
        obs_ready = req_ready;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_op = 0; m_pend = 0; m_id = 0; m_res = '0;
        end else begin
            if (m_pend && rsp_ready) m_pend = 0;
            if (m_op) begin
                m_pend = 1; m_res = m_sum; m_id = m_op_id; m_op = 0;
            end
            if (exp_rdy != '0) begin
                m_op    = 1;
                m_op_id = w;
                m_sum   = req_op1[w*W +: W] + req_op2[w*W +: W];
                m_ptr   = (w + 1) % N_REQ;
            end
        end
        #1;
        cycle++;
        for (int i = 0; i < N_REQ; i++) begin
            if (mode == 0 && exp_rdy[i]) begin
                req_valid[i] = 1'b0;
            end else if (mode == 2) begin
                if (exp_rdy[i] || !req_valid[i])
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
                else if ($urandom_range(0, 19) == 0)
                    req_valid[i] = 1'b0;
            end
        end
        if (mode == 2) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    int q_id[$];
    int q_res[$];
    int q_cyc[$];
    logic [N_REQ-1:0] held_id;
    logic [W-1:0]     held_res;

    initial begin
        rst = 1'b1; req_valid = '0; req_op1 = '0; req_op2 = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset then idle
        do_reset();
        check("reset_rsp_id", obs_id, 0);
        check("reset_rsp_res", obs_res, 0);
        repeat (3) step();
        check("idle_ready", obs_ready, 0);

        // Single requests, including a negative operand
        mode = 0;
        set_req(0, 1'b1, 32'd15, 32'd10);
        step();
        check("single_ready", obs_ready, 4'b0001);
        step(); step();
        check("single_valid", obs_valid, 1);
        check("single_id", obs_id, 0);
        check("single_res", obs_res, 25);
        set_req(0, 1'b1, 32'd20, 32'hFFFF_FFFB);
        step(); step(); step();
        check("neg_res", obs_res, 15);

        // Round-robin fairness with everybody valid
        do_reset();
        mode = 1;
        set_req(0, 1'b1, 32'd33, 32'd11);
        set_req(1, 1'b1, 32'd1, 32'd10);
        set_req(2, 1'b1, 32'd25, 32'd999);
        set_req(3, 1'b1, 32'hFFFF_FFFF, 32'd1);
        for (int n = 0; n < 20; n++) begin
            step();
            if (obs_valid) begin
                q_id.push_back(int'(obs_id));
                q_res.push_back(int'(obs_res));
                q_cyc.push_back(cycle);
            end
        end
        check("rr_count", q_id.size() >= 8, 1);
        for (int n = 0; n < 8 && n < q_id.size(); n++) begin
            int exp_res [4] = '{44, 11, 1024, 0};
            check("rr_id", q_id[n], n % 4);
            check("rr_res", q_res[n], exp_res[n % 4]);
            if (n > 0) check("rr_gap", q_cyc[n] - q_cyc[n-1], 2);
        end

        // Backpressure
        do_reset();
        mode = 0;
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 32'd100, 32'd5);
        set_req(2, 1'b1, 32'd200, 32'd6);
        step(); step();
        step();
        held_id = N_REQ'(obs_id);
        held_res = obs_res;
        check("bp_first_res", obs_res, 105);
        for (int n = 0; n < 4; n++) begin
            step();
            check("bp_ready", obs_ready, 0);
            check("bp_id_stable", obs_id, held_id);
            check("bp_res_stable", obs_res, held_res);
        end
        rsp_ready = 1'b1;
        step();
        check("bp_release_grant", obs_ready, 4'b0100);
        repeat (3) step();

        // Reset mid-operation
        do_reset();
        set_req(0, 1'b1, 32'd7, 32'd8);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 32'd1, 32'd1);
        set_req(3, 1'b1, 32'd2, 32'd2);
        step();
        check("post_rst_grant", obs_ready, 4'b0001);
        for (int n = 0; n < 8; n++) begin
            step();
            if (obs_valid) check("no_rsp15", obs_res == 15, 0);
        end

        // Random traffic with random backpressure and occasional reset
        mode = 2;
        for (int n = 0; n < 3000; n++) step();
        rst = 1'b0;
        mode = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
